// File: rtl/apb4_req_bridge_pkg.sv
// Shared definitions for the APB4 request bridge.
// Holds the FSM encoding, the strobe width and the timeout counter sizing helper.
package apb4_req_bridge_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam int STRB_W          = 4;
  localparam int TIMEOUT_DEFAULT = 255;

  // A disabled timeout (0) still needs a 1-bit counter to keep the RTL legal.
  function automatic int tmo_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/apb4_req_bridge_if.sv
// Request/response channel plus APB4 bus for the bridge.
// The master modport is the bridge itself; slave is the requester and peripheral side.
interface apb4_req_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                                    req_valid;
  logic                                    req_ready;
  logic                                    req_write;
  logic [ADDR_WIDTH-1:0]                   req_addr;
  logic [DATA_WIDTH-1:0]                   req_wdata;
  logic [apb4_req_bridge_pkg::STRB_W-1:0]  req_wstrb;
  logic                                    rsp_valid;
  logic                                    rsp_ready;
  logic [DATA_WIDTH-1:0]                   rsp_rdata;
  logic                                    rsp_err;
  logic [ADDR_WIDTH-1:0]                   paddr;
  logic [2:0]                              pprot;
  logic                                    psel;
  logic                                    penable;
  logic                                    pwrite;
  logic [DATA_WIDTH-1:0]                   pwdata;
  logic [apb4_req_bridge_pkg::STRB_W-1:0]  pstrb;
  logic                                    pready;
  logic [DATA_WIDTH-1:0]                   prdata;
  logic                                    pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
           pready, prdata, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           paddr, pprot, psel, penable, pwrite, pwdata, pstrb
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
           pready, prdata, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           paddr, pprot, psel, penable, pwrite, pwdata, pstrb
  );

endinterface

// File: rtl/apb4_bridge_tmo.sv
// Access-phase timeout: counts enabled cycles since clear, saturating at TIMEOUT.
// expired_o fires on the TIMEOUT-th enabled cycle; TIMEOUT=0 never expires.
module apb4_bridge_tmo
  import apb4_req_bridge_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int            CW   = tmo_width(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != SAT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (TIMEOUT != 0) && en_i && (cnt_q == LAST);

endmodule

// File: rtl/apb4_req_bridge.sv
// Valid/ready register request to single APB4 transfer, one outstanding, with access timeout.
// Accept at T, SETUP T+1, ACCESS T+2.., rsp_valid the cycle after pready; req_ready only in IDLE.
module apb4_req_bridge
  import apb4_req_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
  input logic              pclk,
  input logic              presetn,
  apb4_req_bridge_if.master bus
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  logic [1:0]            state_q, state_d;
  logic                  hold_write_q;
  logic [ADDR_WIDTH-1:0] hold_addr_q;
  logic [DATA_WIDTH-1:0] hold_wdata_q;
  logic [STRB_W-1:0]     hold_wstrb_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  accept, busy, in_access, in_resp, tmo_expired;

  assign accept    = (state_q == ST_IDLE) && bus.req_valid;
  assign busy      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign in_access = (state_q == ST_ACCESS);
  assign in_resp   = (state_q == ST_RESP);

  apb4_bridge_tmo #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk_i     (pclk),
    .rst_ni    (presetn),
    .clear_i   (accept),
    .en_i      (in_access),
    .expired_o (tmo_expired)
  );

  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE:   if (bus.req_valid) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        // A slave answering on the expiry cycle still completes normally.
        if (bus.pready) begin
          state_d     = ST_RESP;
          rsp_rdata_d = hold_write_q ? '0 : bus.prdata;
          rsp_err_d   = bus.pslverr;
        end else if (tmo_expired) begin
          state_d     = ST_RESP;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end
      end
      ST_RESP:   if (bus.rsp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= ST_IDLE;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      hold_write_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      hold_wstrb_q <= '0;
    end else if (accept) begin
      hold_write_q <= bus.req_write;
      hold_addr_q  <= bus.req_addr;
      hold_wdata_q <= bus.req_wdata;
      hold_wstrb_q <= bus.req_wstrb;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = in_resp;
  assign bus.rsp_rdata = in_resp ? rsp_rdata_q : '0;
  assign bus.rsp_err   = in_resp & rsp_err_q;

  assign bus.psel    = busy;
  assign bus.penable = in_access;
  assign bus.pprot   = 3'b000;
  assign bus.paddr   = busy ? (hold_addr_q & ADDR_MASK) : '0;
  assign bus.pwrite  = busy & hold_write_q;
  assign bus.pwdata  = (busy && hold_write_q) ? hold_wdata_q : '0;
  assign bus.pstrb   = (busy && hold_write_q) ? hold_wstrb_q : '0;

endmodule

// File: tb/tb_apb4_req_bridge.sv
// Directed bench for apb4_req_bridge with TIMEOUT=8.
// Inputs change and outputs are sampled on the falling edge.
module tb_apb4_req_bridge;

  logic pclk = 1'b0;
  logic presetn;
  int   tests = 0;
  int   fails = 0;
  int   n;
  logic [31:0] seen_addr;

  always #5 pclk = ~pclk;

  apb4_req_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb4_req_bridge #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .TIMEOUT    (8)
  ) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge pclk);
  endtask

  initial begin
    presetn       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;
    bus.rsp_ready = 1'b0;
    bus.pready    = 1'b0;
    bus.prdata    = '0;
    bus.pslverr   = 1'b0;
    tick();
    tick();
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_psel", bus.psel, 0);
    chk("rst_penable", bus.penable, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_paddr", bus.paddr, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    presetn = 1'b1;

    // Read 0x4, zero-wait slave
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h4;
    bus.req_wdata = 32'h1111_1111; bus.req_wstrb = 4'hF;
    bus.pready = 1'b1; bus.prdata = 32'hDEAD_BEEF;
    chk("rd_accept_ready", bus.req_ready, 1);
    tick();
    chk("rd_setup_psel", bus.psel, 1);
    chk("rd_setup_penable", bus.penable, 0);
    chk("rd_setup_paddr", bus.paddr, 32'h4);
    chk("rd_setup_pwrite", bus.pwrite, 0);
    chk("rd_setup_pwdata", bus.pwdata, 0);
    chk("rd_setup_pstrb", bus.pstrb, 0);
    chk("rd_setup_req_ready", bus.req_ready, 0);
    bus.req_valid = 1'b0; bus.req_addr = 32'hFFFF_FFF0;
    tick();
    chk("rd_access_psel", bus.psel, 1);
    chk("rd_access_penable", bus.penable, 1);
    chk("rd_access_paddr", bus.paddr, 32'h4);
    tick();
    chk("rd_rsp_valid", bus.rsp_valid, 1);
    chk("rd_rsp_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
    chk("rd_rsp_err", bus.rsp_err, 0);
    chk("rd_rsp_psel", bus.psel, 0);
    bus.rsp_ready = 1'b1;
    tick();
    chk("rd_done_rsp_valid", bus.rsp_valid, 0);
    chk("rd_done_req_ready", bus.req_ready, 1);
    bus.rsp_ready = 1'b0;

    // Write 0x10 with three wait states
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h10;
    bus.req_wdata = 32'h1234_5678; bus.req_wstrb = 4'hF; bus.pready = 1'b0;
    tick();
    chk("wr_setup_penable", bus.penable, 0);
    chk("wr_setup_pwrite", bus.pwrite, 1);
    chk("wr_setup_paddr", bus.paddr, 32'h10);
    chk("wr_setup_pwdata", bus.pwdata, 32'h1234_5678);
    chk("wr_setup_pstrb", bus.pstrb, 4'hF);
    bus.req_valid = 1'b0; bus.req_wdata = 32'h0; bus.req_wstrb = 4'h0; bus.req_write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wr_wait_penable", bus.penable, 1);
      chk("wr_wait_psel", bus.psel, 1);
      chk("wr_wait_paddr", bus.paddr, 32'h10);
      chk("wr_wait_pwdata", bus.pwdata, 32'h1234_5678);
      chk("wr_wait_pstrb", bus.pstrb, 4'hF);
      chk("wr_wait_pwrite", bus.pwrite, 1);
    end
    bus.pready = 1'b1; bus.prdata = 32'hFFFF_FFFF;
    tick();
    chk("wr_rsp_valid", bus.rsp_valid, 1);
    chk("wr_rsp_rdata", bus.rsp_rdata, 0);
    chk("wr_rsp_err", bus.rsp_err, 0);
    bus.rsp_ready = 1'b1;
    tick();
    chk("wr_done_rsp_valid", bus.rsp_valid, 0);
    bus.rsp_ready = 1'b0;

    // Read with slave error
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h8;
    bus.pready = 1'b1; bus.pslverr = 1'b1; bus.prdata = 32'hCAFE_0001;
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    chk("err_rsp_valid", bus.rsp_valid, 1);
    chk("err_rsp_err", bus.rsp_err, 1);
    chk("err_rsp_rdata", bus.rsp_rdata, 32'hCAFE_0001);
    bus.rsp_ready = 1'b1; bus.pslverr = 1'b0;
    tick();
    chk("err_done_rsp_valid", bus.rsp_valid, 0);
    chk("err_no_retry_psel0", bus.psel, 0);
    tick();
    chk("err_no_retry_psel1", bus.psel, 0);
    bus.rsp_ready = 1'b0;

    // Slave never ready: access phase ends after 8 cycles
    bus.req_valid = 1'b1; bus.req_addr = 32'hC; bus.pready = 1'b0; bus.prdata = 32'h1234_5678;
    tick();
    chk("tmo_setup_penable", bus.penable, 0);
    bus.req_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.penable) n++;
      else break;
    end
    chk("tmo_access_len", n, 8);
    chk("tmo_rsp_valid", bus.rsp_valid, 1);
    chk("tmo_rsp_err", bus.rsp_err, 1);
    chk("tmo_rsp_rdata", bus.rsp_rdata, 0);
    chk("tmo_psel", bus.psel, 0);
    bus.rsp_ready = 1'b1;
    tick();
    chk("tmo_done_req_ready", bus.req_ready, 1);
    bus.rsp_ready = 1'b0;

    // Response backpressure, then back-to-back requests
    bus.req_valid = 1'b1; bus.req_addr = 32'h14; bus.pready = 1'b1; bus.prdata = 32'h55AA_55AA;
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    bus.req_valid = 1'b1; bus.req_addr = 32'h23; bus.prdata = 32'h0BAD_0000;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", bus.rsp_valid, 1);
      chk("bp_rsp_rdata", bus.rsp_rdata, 32'h55AA_55AA);
      chk("bp_req_ready", bus.req_ready, 0);
      tick();
    end
    chk("bp_still_valid", bus.rsp_valid, 1);
    bus.rsp_ready = 1'b1;
    tick();
    chk("b2b_first_ready", bus.req_ready, 1);
    for (int r = 0; r < 2; r++) begin
      n = 0;
      seen_addr = 32'hFFFF_FFFF;
      for (int i = 0; i < 12; i++) begin
        tick();
        n++;
        if (bus.psel && !bus.penable) seen_addr = bus.paddr;
        if (bus.req_ready) break;
      end
      chk("b2b_cycles", n, 4);
      chk("b2b_paddr_aligned", seen_addr, 32'h20);
    end
    bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
    tick();

    // Asynchronous reset during the access phase
    bus.req_valid = 1'b1; bus.req_addr = 32'h30; bus.pready = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("arst_pre_penable", bus.penable, 1);
    #2 presetn = 1'b0;
    #1;
    chk("arst_psel", bus.psel, 0);
    chk("arst_penable", bus.penable, 0);
    chk("arst_req_ready", bus.req_ready, 1);
    bus.pready = 1'b1;
    tick();
    presetn = 1'b1;
    tick();
    chk("arst_after_req_ready", bus.req_ready, 1);
    chk("arst_after_rsp_valid", bus.rsp_valid, 0);
    chk("arst_after_psel", bus.psel, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
